// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port among video, data and fetch.
// One single-word access at a time, with a watchdog on controller completion.
module sdram_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              v_req,
  input  logic              d_req,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              d_wren,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              v_ack,
  output logic              d_ack,
  output logic              f_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_V,
    G_D,
    G_F
  } gnt_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  logic              rr_last_q, rr_last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              terr_q, terr_d;
  logic              start_q, start_d;
  logic              v_ack_q, v_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              f_ack_q, f_ack_d;
  logic              busy_q, busy_d;

  logic any_req;
  logic d_win;
  logic f_win;

  // rr_last_q set means F was the last D/F winner, so D goes next
  assign any_req = v_req | d_req | f_req;
  assign d_win   = !v_req && d_req && (!f_req || rr_last_q);
  assign f_win   = !v_req && f_req && (!d_req || !rr_last_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wren_d    = wren_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    terr_d    = terr_q;
    start_d   = 1'b0;
    v_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_ack_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
          unique case (1'b1)
            v_req: begin
              gnt_d   = G_V;
              addr_d  = v_addr;
              wren_d  = 1'b0;
              wdata_d = '0;
            end
            d_win: begin
              gnt_d     = G_D;
              addr_d    = d_addr;
              wren_d    = d_wren;
              wdata_d   = d_wdata;
              rr_last_d = 1'b0;
            end
            f_win: begin
              gnt_d     = G_F;
              addr_d    = f_addr;
              wren_d    = 1'b0;
              wdata_d   = '0;
              rr_last_d = 1'b1;
            end
            default: begin
              gnt_d = G_NONE;
            end
          endcase
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done) begin
          if (!wren_q) begin
            rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_MAX) begin
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (state_d == S_DONE) begin
          v_ack_d = (gnt_q == G_V);
          d_ack_d = (gnt_q == G_D);
          f_ack_d = (gnt_q == G_F);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= G_NONE;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      addr_q    <= '0;
      wren_q    <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      terr_q    <= 1'b0;
      start_q   <= 1'b0;
      v_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wren_q    <= wren_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      terr_q    <= terr_d;
      start_q   <= start_d;
      v_ack_q   <= v_ack_d;
      d_ack_q   <= d_ack_d;
      f_ack_q   <= f_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign v_ack       = v_ack_q;
  assign d_ack       = d_ack_q;
  assign f_ack       = f_ack_q;
  assign rdata       = rdata_q;
  assign mem_start   = start_q;
  assign mem_addr    = addr_q;
  assign mem_wren    = wren_q;
  assign mem_wdata   = wdata_q;
  assign timeout_err = terr_q;
  assign busy        = busy_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port among three requesters: video scan-out (port V), CU data load/store (port D, driven from the CU stage-5 RW operation) and instruction fetch/cache refill (port F).
- Grants one single-word access at a time and forwards it to the controller.
- Returns read data and an ack pulse to the winner.
- Provides a watchdog so a hung controller cannot deadlock the CPU pipeline.

Parameters:
ADDR_W, 22, word address width (matches sdram_mem_addr).
DATA_W, 16, SDRAM data word width.
TIMEOUT, 255, max cycles in WAIT before forced completion; must be ≥2 and fit in 8 bits.

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low: reset==0 at a rising edge resets the block
v_req, d_req, f_req  in  1 each  request level; held until own ack
v_addr, d_addr, f_addr  in  ADDR_W each  word address
d_wren  in  1  port D write (V and F are read-only)
d_wdata  in  DATA_W  port D write data
v_ack, d_ack, f_ack  out  1 each  one-cycle completion pulse
rdata  out  DATA_W  read data, valid in ack cycle
mem_start  out  1  one-cycle operation strobe to controller
mem_addr  out  ADDR_W  registered address
mem_wren  out  1  registered write flag
mem_wdata  out  DATA_W  registered write data
mem_done  in  1  controller completion pulse
mem_rdata  in  DATA_W  controller read data, valid with mem_done
timeout_err  out  1  sticky: a forced completion has occurred
busy  out  1  state != IDLE

Behaviour:
- Reset values: all acks 0, mem_start 0, mem_addr/mem_wdata/rdata 0, mem_wren 0, timeout_err 0, state IDLE, rr_last = F, wait counter 0.
- Reset while not IDLE aborts the access. No ack is issued. The controller shares the same reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, latch the grant, mem_addr, mem_wren (D: d_wren; V/F: 0) and mem_wdata. Go to ISSUE.
  - Otherwise stay in IDLE.
- Priority:
  - V always wins.
  - Otherwise D and F round-robin: if both request, grant the one not equal to rr_last. A single requester wins unconditionally.
  - rr_last updates only on a D or F grant.
- ISSUE: mem_start=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
- WAIT:
  - mem_done=1: register mem_rdata into rdata (reads only; writes leave rdata unchanged). Go to DONE.
  - Else if counter == TIMEOUT-1: set timeout_err. Go to DONE; rdata unchanged.
  - Else increment the counter.
  - mem_done and timeout in the same cycle counts as a normal completion; timeout_err is not set.
- DONE: assert the granted port's ack for this cycle only. Go to IDLE.
- mem_done outside WAIT is ignored.
- Requester rule: drop req on the edge ending the ack cycle; a new request may be raised in the following cycle. The arbiter never samples req in DONE, so no double grant occurs.
- Minimum latency: req seen in IDLE at cycle t, mem_start at t+1, mem_done earliest t+2, ack at t+3, next grant decision at t+4.
- Request inputs are not required to be stable before grant. Address and data are captured only at the IDLE→ISSUE edge and ignored afterwards.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Single D read: addr=0x12345, controller returns 0xBEEF 3 cycles after mem_start -> mem_start 1 cycle with mem_addr=0x12345, mem_wren=0; d_ack exactly 1 cycle with rdata=0xBEEF; v_ack/f_ack stay 0.
- D write: d_wren=1, d_wdata=0x5A5A -> mem_wren=1, mem_wdata=0x5A5A; d_ack pulse; rdata keeps its previous value.
- D and F held continuously after reset -> grants alternate D,F,D,F. Add V mid-sequence -> V served at the next IDLE, then round-robin resumes from where it left off.
- Controller never asserts mem_done, TIMEOUT=255 -> ack appears exactly 255 cycles after the WAIT entry; timeout_err=1 and stays 1 until reset==0.
- mem_done coincides with the final timeout cycle -> normal ack, timeout_err stays 0.
- reset==0 for one cycle while in WAIT -> next cycle state IDLE, no ack, mem_start 0; a subsequent request completes normally.
